// File: rtl/bcd_score_counter.sv
// -----------------------------------------------------------------------------
// bcd_score_counter
//
// Parametrised N-digit packed-BCD up/down score counter for a scoreboard.
// The raw inc/dec level inputs are synchronised and edge-detected. Each rising
// edge steps the score by +1 or -1. The counter can either wrap modulo
// 10^NDIGITS or saturate at 0 and at the maximum. A synchronous parallel load
// is provided, and its value is clamped digit-by-digit to the range 0..9.
//
// Parameters
//   NDIGITS  number of BCD digits, 1..8 (range 0 .. 10^NDIGITS-1)
//   WRAP     1: wrap at the boundaries, 0: saturate
//   DB_CYC   debounce stability window in clk cycles (>=2)
//
// Build option
//   BCD_DEBOUNCE_EN  when defined, a debounce filter is inserted per input
//                    between the synchroniser and the edge detector.
//                    When undefined, no debounce logic exists.
//
// Ports
//   clk       in   rising-edge system clock
//   reset     in   asynchronous active-low reset
//   inc       in   raw increment request (async level)
//   dec       in   raw decrement request (async level)
//   load      in   synchronous parallel load strobe
//   load_val  in   packed BCD load value, digit 0 in [3:0]
//   digits    out  packed BCD score, digit 0 in [3:0]
//   is_zero   out  all digits are 0
//   is_max    out  all digits are 9
//   wrapped   out  one-cycle pulse after a wrapping update (WRAP=1 only)
// -----------------------------------------------------------------------------
module bcd_score_counter #(
    parameter int NDIGITS = 2,
    parameter int WRAP    = 1,
    parameter int DB_CYC  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    output logic [4*NDIGITS-1:0]   digits,
    output logic                   is_zero,
    output logic                   is_max,
    output logic                   wrapped
);

    localparam int             W         = 4 * NDIGITS;
    localparam logic           WRAP_EN   = (WRAP != 0);
    localparam logic [W-1:0]   ALL_NINES = {NDIGITS{4'd9}};
    localparam logic [W-1:0]   ALL_ZEROS = {W{1'b0}};

    // Elaboration-time parameter sanity checks.
    if ((NDIGITS < 1) || (NDIGITS > 8)) begin : g_bad_ndigits
        $error("bcd_score_counter: NDIGITS must be in 1..8");
    end
    if (DB_CYC < 2) begin : g_bad_db_cyc
        $error("bcd_score_counter: DB_CYC must be >= 2");
    end

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // +1 with ripple carry: a 9 becomes 0 and passes the carry upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // -1 with ripple borrow: a 0 becomes 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Clamp any non-BCD nibble (A..F) to 9 so the score register
    // only ever holds legal BCD.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input path: bit 0 = inc, bit 1 = dec
    // ------------------------------------------------------------------
    logic [1:0] sync1_r;
    logic [1:0] sync2_r;
    logic [1:0] prev_r;
    logic [1:0] filt_s;
    logic [1:0] ev_s;

    // Two-flop synchroniser plus the edge-detector history flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            prev_r  <= 2'b00;
        end else begin
            sync1_r <= {dec, inc};
            sync2_r <= sync1_r;
            prev_r  <= filt_s;
        end
    end

`ifdef BCD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYC + 1);

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [CNT_W-1:0] cnt_r;
        logic             filt_r;

        // Debounce filter. filt takes the value of sync2 only after a run of
        // uninterrupted disagreement. Any agreement restarts the window.
        // The cycle on which sync2 itself changed already counts as the first
        // cycle of that run. As a result, the total latency from a stable
        // input to the score update is DB_CYC+2 edges.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_r  <= {CNT_W{1'b0}};
                filt_r <= 1'b0;
            end else if (sync2_r[g] == filt_r) begin
                cnt_r  <= {CNT_W{1'b0}};
                filt_r <= filt_r;
            end else if (cnt_r == CNT_W'(DB_CYC - 2)) begin
                cnt_r  <= {CNT_W{1'b0}};
                filt_r <= sync2_r[g];
            end else begin
                cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                filt_r <= filt_r;
            end
        end

        assign filt_s[g] = filt_r;
    end
`else
    assign filt_s = sync2_r;
`endif

    assign ev_s = filt_s & ~prev_r;

    // ------------------------------------------------------------------
    // Score update
    // ------------------------------------------------------------------
    logic [W-1:0] digits_r;
    logic         wrapped_r;
    logic [W-1:0] digits_next_s;
    logic         wrapped_next_s;
    logic         net_inc_s;
    logic         net_dec_s;
    logic         at_max_s;
    logic         at_zero_s;

    assign at_max_s  = (digits_r == ALL_NINES);
    assign at_zero_s = (digits_r == ALL_ZEROS);

    // Next-score selection: load beats events, and opposing events cancel.
    always_comb begin
        digits_next_s  = digits_r;
        wrapped_next_s = 1'b0;
        net_inc_s      = ev_s[0] & ~ev_s[1];
        net_dec_s      = ev_s[1] & ~ev_s[0];

        if (load) begin
            digits_next_s = bcd_clamp(load_val);
        end else if (net_inc_s) begin
            if (at_max_s) begin
                if (WRAP_EN) begin
                    digits_next_s  = ALL_ZEROS;
                    wrapped_next_s = 1'b1;
                end else begin
                    digits_next_s = digits_r;
                end
            end else begin
                digits_next_s = bcd_inc(digits_r);
            end
        end else if (net_dec_s) begin
            if (at_zero_s) begin
                if (WRAP_EN) begin
                    digits_next_s  = ALL_NINES;
                    wrapped_next_s = 1'b1;
                end else begin
                    digits_next_s = digits_r;
                end
            end else begin
                digits_next_s = bcd_dec(digits_r);
            end
        end else begin
            digits_next_s = digits_r;
        end
    end

    // Score and wrap-pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_r  <= ALL_ZEROS;
            wrapped_r <= 1'b0;
        end else begin
            digits_r  <= digits_next_s;
            wrapped_r <= wrapped_next_s;
        end
    end

    assign digits  = digits_r;
    assign wrapped = wrapped_r;
    assign is_zero = at_zero_s;
    assign is_max  = at_max_s;

endmodule

// File: tb/tb_bcd_score_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_score_counter
//
// Two instances share the same stimulus:
//   dut_a : NDIGITS=2, WRAP=1
//   dut_b : NDIGITS=3, WRAP=0
// The expected score is held as a plain integer and moved by +1/-1 with
// modulo or saturating arithmetic. Raw inputs are kept as an edge-sampled
// history, and an event fires when the sample from two edges ago is high and
// the sample from three edges ago is low.
// -----------------------------------------------------------------------------
module tb_bcd_score_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inc;
    logic        dec;
    logic        load;
    logic [11:0] load_val;

    logic [7:0]  digits_a;
    logic        is_zero_a, is_max_a, wrapped_a;
    logic [11:0] digits_b;
    logic        is_zero_b, is_max_b, wrapped_b;

    int n_checks = 0;
    int n_errors = 0;

    int sc_a, sc_b;
    bit wr_a, wr_b;
    bit hi [3];
    bit hd [3];

    always #5 clk = ~clk;

    bcd_score_counter #(.NDIGITS(2), .WRAP(1), .DB_CYC(16)) dut_a (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val[7:0]), .digits(digits_a), .is_zero(is_zero_a),
        .is_max(is_max_a), .wrapped(wrapped_a)
    );

    bcd_score_counter #(.NDIGITS(3), .WRAP(0), .DB_CYC(16)) dut_b (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .digits(digits_b), .is_zero(is_zero_b),
        .is_max(is_max_b), .wrapped(wrapped_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        int          x;
        r = 32'd0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_load(input logic [11:0] lv, input int nd);
        int v;
        int dg;
        v = 0;
        for (int i = 0; i < nd; i++) begin
            dg = int'(lv[4*i +: 4]);
            if (dg > 9) dg = 9;
            v = v + dg * pow10(i);
        end
        return v;
    endfunction

    task automatic model_reset();
        sc_a = 0; sc_b = 0; wr_a = 1'b0; wr_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hi[i] = 1'b0;
            hd[i] = 1'b0;
        end
    endtask

    task automatic apply(inout int s, output bit w, input int nd, input bit wrap_en,
                         input bit ei, input bit ed);
        int mx;
        mx = pow10(nd) - 1;
        w  = 1'b0;
        if (load) begin
            s = clamp_load(load_val, nd);
        end else if (ei && !ed) begin
            if (s == mx) begin
                if (wrap_en) begin s = 0; w = 1'b1; end
            end else begin
                s = s + 1;
            end
        end else if (ed && !ei) begin
            if (s == 0) begin
                if (wrap_en) begin s = mx; w = 1'b1; end
            end else begin
                s = s - 1;
            end
        end
    endtask

    // Model of one rising edge. Call it right after the posedge, while the
    // inputs still hold the values that the DUT sampled on that edge.
    task automatic model_edge();
        bit ei, ed;
        if (!reset) begin
            model_reset();
        end else begin
            ei = hi[1] & ~hi[2];
            ed = hd[1] & ~hd[2];
            hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = inc;
            hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = dec;
            apply(sc_a, wr_a, 2, 1'b1, ei, ed);
            apply(sc_b, wr_b, 3, 1'b0, ei, ed);
        end
    endtask

    task automatic check_all();
        check("a_digits",  32'(digits_a),  to_bcd(sc_a, 2));
        check("a_is_zero", 32'(is_zero_a), 32'(sc_a == 0));
        check("a_is_max",  32'(is_max_a),  32'(sc_a == 99));
        check("a_wrapped", 32'(wrapped_a), 32'(wr_a));
        check("b_digits",  32'(digits_b),  to_bcd(sc_b, 3));
        check("b_is_zero", 32'(is_zero_b), 32'(sc_b == 0));
        check("b_is_max",  32'(is_max_b),  32'(sc_b == 999));
        check("b_wrapped", 32'(wrapped_b), 32'(wr_b));
    endtask

    // One clock cycle: drive the inputs, take the edge, then check 1 time unit later.
    task automatic cyc(input bit i, input bit d, input bit l, input logic [11:0] lv);
        inc = i; dec = d; load = l; load_val = lv;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse(input bit i, input bit d, input int hi_cycles);
        for (int k = 0; k < hi_cycles; k++) cyc(i, d, 1'b0, 12'h000);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    // Assert reset between edges and check the effect with no clock edge in between.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b0, 1'b1, 1'b0, 12'h000);
        reset = 1'b1;
    endtask

    initial begin
        bit          ri, rd, rl;
        logic [11:0] lv;

        reset = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_val = 12'h000;
        model_reset();
        #1;
        check_all();
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        reset = 1'b1;

        // Asynchronous reset mid-count at 37.
        cyc(1'b0, 1'b0, 1'b1, 12'h037);
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        async_reset();

        // Carry and borrow from 09, with inc held high for 20 cycles.
        cyc(1'b0, 1'b0, 1'b1, 12'h009);
        pulse(1'b1, 1'b0, 20);
        pulse(1'b0, 1'b1, 2);
        // 99 -> wrap (A) / 099 -> 100 (B), then back down again.
        cyc(1'b0, 1'b0, 1'b1, 12'h099);
        pulse(1'b1, 1'b0, 2);
        pulse(1'b0, 1'b1, 2);

        // Saturation on B at 999 and at 000.
        cyc(1'b0, 1'b0, 1'b1, 12'h999);
        for (int k = 0; k < 5; k++) pulse(1'b1, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b1, 12'h000);
        for (int k = 0; k < 3; k++) pulse(1'b0, 1'b1, 1);

        // Opposing events cancel, and load beats a coincident inc event.
        cyc(1'b0, 1'b0, 1'b1, 12'h055);
        pulse(1'b1, 1'b1, 3);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b1, 12'h04C);
        pulse(1'b1, 1'b0, 4);

        // Randomised traffic.
        ri = 1'b0; rd = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 2) == 0) ri = ~ri;
            if ($urandom_range(0, 2) == 0) rd = ~rd;
            rl = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       lv = 12'h999;
                1:       lv = 12'h000;
                2:       lv = 12'h099;
                default: lv = 12'($urandom);
            endcase
            cyc(ri, rd, rl, lv);
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
